// File: rtl/spi_bitrev_ctrl_if.sv
// Request/response handshake bundle between the CPU-side MMIO glue and the
// SPI bit-reverse controller. The master modport is the requester (MMIO glue
// or testbench); the slave modport is the controller itself.
interface spi_bitrev_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/spi_bitrev_ctrl.sv
// SPI master that runs one bit-reverse transaction per accepted request:
// frames the byte with SS low, shifts it out MSB first, clocks the reply back
// in and hands it out on the response port. SCK, SS and MOSI are all driven
// straight from flops so the pins never glitch.
// Optional build macro SPI_BITREV_CHECK_EN adds chk_err / chk_err_sticky, which
// compare each reply against the bit-reverse of the request byte.
module spi_bitrev_ctrl #(
    parameter int DIV     = 2,
    parameter int GAP     = 2,
    parameter int TX_BITS = 8,
    parameter int RX_BITS = 8
) (
    input  logic             clock,
    input  logic             resetn,
    spi_bitrev_ctrl_if.slave bus,
    output logic             busy,
    output logic             sck,
    output logic             ss,
    output logic             mosi,
    input  logic             miso
`ifdef SPI_BITREV_CHECK_EN
    ,
    output logic             chk_err,
    output logic             chk_err_sticky
`endif
);

    localparam int TOTAL_BITS = TX_BITS + RX_BITS;
    localparam int CW         = 9;
    localparam int BW         = $clog2(TOTAL_BITS + 1);

    localparam logic [CW-1:0] DIV_C    = CW'(DIV);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] PERIOD_M1 = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(GAP - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL_BITS - 1);
    localparam logic [BW-1:0] TX_LAST  = BW'(TX_BITS - 1);
    localparam logic [BW-1:0] TX_BITS_C = BW'(TX_BITS);
    localparam logic [7:0]    RX_MASK  = 8'((9'd1 << RX_BITS) - 9'd1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      tx_sr_q, tx_sr_d;
    logic [7:0]      rx_sr_q, rx_sr_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            mosi_q, mosi_d;
    logic            sck_q, sck_d;
    logic            ss_q, ss_d;
    logic            busy_q, busy_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            gap_exit;

    // Next-state, counters and shift registers; pin values derive from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rsp_data_d = rsp_data_q;
        mosi_d     = mosi_q;
        gap_exit   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                mosi_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    tx_sr_d   = bus.req_data;
                    rx_sr_d   = '0;
                    mosi_d    = bus.req_data[7];
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                mosi_d = tx_sr_q[7];
                if (div_cnt_q == DIV_M1) begin
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (div_cnt_q == DIV_M1) begin
                    if (bit_cnt_q < TX_LAST) begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        mosi_d  = tx_sr_q[6];
                    end else if (bit_cnt_q == TX_LAST) begin
                        mosi_d = 1'b1;
                    end
                    if (bit_cnt_q >= TX_BITS_C) begin
                        rx_sr_d = {rx_sr_q[6:0], miso};
                    end
                end
                if (div_cnt_q == PERIOD_M1) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (div_cnt_q == DIV_M1) begin
                    div_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (div_cnt_q == GAP_M1) begin
                    div_cnt_d  = '0;
                    rsp_data_d = rx_sr_q & RX_MASK;
                    gap_exit   = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sck_d       = (state_d == ST_SHIFT) && (div_cnt_d < DIV_C);
        ss_d        = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
        busy_d      = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                      (state_d == ST_HOLD)  || (state_d == ST_GAP);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers; reset drops any frame in flight and parks the pins idle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rsp_data_q  <= '0;
            mosi_q      <= 1'b1;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rsp_data_q  <= rsp_data_d;
            mosi_q      <= mosi_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = busy_q;
    assign sck           = sck_q;
    assign ss            = ss_q;
    assign mosi          = mosi_q;

`ifdef SPI_BITREV_CHECK_EN
    logic [7:0] req_byte_q, req_byte_d;
    logic       chk_err_q, chk_err_d;
    logic       chk_sticky_q, chk_sticky_d;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7 - i];
        end
        return r;
    endfunction

    // Remember the request byte and grade the reply against its reverse when the reply is published
    always_comb begin
        req_byte_d   = req_byte_q;
        chk_err_d    = chk_err_q;
        chk_sticky_d = chk_sticky_q;
        if ((state_q == ST_IDLE) && bus.req_valid && req_ready_q) begin
            req_byte_d = bus.req_data;
        end
        if (gap_exit) begin
            chk_err_d    = (rsp_data_d != bitrev8(req_byte_q));
            chk_sticky_d = chk_sticky_q | chk_err_d;
        end
    end

    // Checker registers; the sticky flag only clears on reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            req_byte_q   <= '0;
            chk_err_q    <= 1'b0;
            chk_sticky_q <= 1'b0;
        end else begin
            req_byte_q   <= req_byte_d;
            chk_err_q    <= chk_err_d;
            chk_sticky_q <= chk_sticky_d;
        end
    end

    assign chk_err        = chk_err_q;
    assign chk_err_sticky = chk_sticky_q;
`endif

endmodule

// File: tb/tb_spi_bitrev_ctrl.sv
// Self-checking bench for spi_bitrev_ctrl. Two controllers run side by side:
// one with default timing (DIV=2, GAP=2) and one at DIV=1, GAP=1. Each is
// wired to a behavioural bit-reverse peripheral that samples MOSI on rising
// SCK and returns the reversed byte MSB first on later rising edges.
`timescale 1ns/1ps
module tb_spi_bitrev_ctrl;

    logic clock = 1'b0;
    logic resetn;
    logic forceZero = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // 100 MHz system clock
    always #5 clock = ~clock;

    spi_bitrev_ctrl_if busA ();
    spi_bitrev_ctrl_if busB ();

    logic busyA, sckA, ssA, mosiA, misoA;
    logic busyB, sckB, ssB, mosiB, misoB;
`ifdef SPI_BITREV_CHECK_EN
    logic chkA, chkStickyA, chkB, chkStickyB;
`endif

    spi_bitrev_ctrl dutA (
        .clock  (clock),
        .resetn (resetn),
        .bus    (busA),
        .busy   (busyA),
        .sck    (sckA),
        .ss     (ssA),
        .mosi   (mosiA),
        .miso   (misoA)
`ifdef SPI_BITREV_CHECK_EN
        ,
        .chk_err        (chkA),
        .chk_err_sticky (chkStickyA)
`endif
    );

    spi_bitrev_ctrl #(.DIV(1), .GAP(1)) dutB (
        .clock  (clock),
        .resetn (resetn),
        .bus    (busB),
        .busy   (busyB),
        .sck    (sckB),
        .ss     (ssB),
        .mosi   (mosiB),
        .miso   (misoB)
`ifdef SPI_BITREV_CHECK_EN
        ,
        .chk_err        (chkB),
        .chk_err_sticky (chkStickyB)
`endif
    );

    logic [1:0] sckV, ssV, mosiV;
    assign sckV  = {sckB, sckA};
    assign ssV   = {ssB, ssA};
    assign mosiV = {mosiB, mosiA};

    // Behavioural peripheral per controller; SS high resets its frame state
    for (genvar g = 0; g < 2; g++) begin : slv
        logic [7:0] rxByte = 8'h00;
        logic [7:0] txByte = 8'h00;
        logic       misoQ  = 1'b0;
        int         edgeCnt = 0;
        int         frameEdges = 0;
        int         strayEdges = 0;

        always @(posedge sckV[g] or posedge ssV[g]) begin
            if (ssV[g]) begin
                frameEdges = edgeCnt;
                edgeCnt    = 0;
                rxByte     = 8'h00;
                misoQ      = 1'b0;
            end else begin
                if (edgeCnt < 8) begin
                    rxByte = {rxByte[6:0], mosiV[g]};
                end else begin
                    if (edgeCnt == 8) begin
                        for (int i = 0; i < 8; i++) begin
                            txByte[i] = rxByte[7 - i];
                        end
                        if (forceZero) begin
                            txByte = 8'h00;
                        end
                    end
                    misoQ  = txByte[7];
                    txByte = {txByte[6:0], 1'b0};
                end
                edgeCnt++;
            end
        end

        always @(posedge sckV[g]) begin
            if (ssV[g]) begin
                strayEdges++;
            end
        end
    end

    assign misoA = slv[0].misoQ;
    assign misoB = slv[1].misoQ;

    // Length of the most recent SS-high stretch on the default-timing controller
    int highRun = 0;
    int lastGap = 0;
    always @(negedge clock) begin
        if (ssA) begin
            highRun++;
        end else begin
            if (highRun > 0) begin
                lastGap = highRun;
            end
            highRun = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic reqReady(input bit sel);
        return sel ? busB.req_ready : busA.req_ready;
    endfunction

    function automatic logic rspValid(input bit sel);
        return sel ? busB.rsp_valid : busA.rsp_valid;
    endfunction

    function automatic logic [7:0] rspData(input bit sel);
        return sel ? busB.rsp_data : busA.rsp_data;
    endfunction

    task automatic setReq(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            busB.req_valid = v;
            busB.req_data  = d;
        end else begin
            busA.req_valid = v;
            busA.req_data  = d;
        end
    endtask

    task automatic setRspReady(input bit sel, input logic r);
        if (sel) busB.rsp_ready = r;
        else     busA.rsp_ready = r;
    endtask

    // One full request/response exchange with latency, data, frame and stall checks
    task automatic applyStimulus(input bit sel, input logic [7:0] din, input logic [7:0] expData,
                                 input int expLat, input int holdCycles, input logic expChk,
                                 input string tag);
        int cycles;
        cycles = 0;
        while (!reqReady(sel) && cycles < 20) begin
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput({tag, " req_ready"}, 32'(reqReady(sel)), 32'd1);
        setReq(sel, 1'b1, din);
        @(posedge clock); #1;
        setReq(sel, 1'b0, 8'h00);
        cycles = 1;
        while (!rspValid(sel) && cycles < 500) begin
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, " rsp_data"}, 32'(rspData(sel)), 32'(expData));
        checkOutput({tag, " sck edges"}, 32'(sel ? slv[1].frameEdges : slv[0].frameEdges), 32'd16);
`ifdef SPI_BITREV_CHECK_EN
        checkOutput({tag, " chk_err"}, 32'(sel ? chkB : chkA), 32'(expChk));
`else
        if (expChk) $display("[TB] note: %s expects a checker flag that is not built in", tag);
`endif
        for (int i = 0; i < holdCycles; i++) begin
            setReq(sel, logic'(i % 2), 8'hFF);
            @(posedge clock); #1;
            checkOutput({tag, " stall rsp_data"}, 32'(rspData(sel)), 32'(expData));
            checkOutput({tag, " stall req_ready"}, 32'(reqReady(sel)), 32'd0);
        end
        if (holdCycles > 0) begin
            setReq(sel, 1'b0, 8'h00);
            checkOutput({tag, " stall rsp_valid"}, 32'(rspValid(sel)), 32'd1);
            checkOutput({tag, " stall no sck"}, 32'(sel ? slv[1].edgeCnt : slv[0].edgeCnt), 32'd0);
            checkOutput({tag, " stall ss"}, 32'(sel ? ssB : ssA), 32'd1);
        end
        setRspReady(sel, 1'b1);
        @(posedge clock); #1;
        setRspReady(sel, 1'b0);
        checkOutput({tag, " rsp_valid drop"}, 32'(rspValid(sel)), 32'd0);
        checkOutput({tag, " ready again"}, 32'(reqReady(sel)), 32'd1);
    endtask

    // Hard bound on total run time
    initial begin
        #400000;
        $display("[TB] FAIL timeout: got no finish expected finish before 400us");
        $fatal(1, "[TB] run did not complete");
    end

    // Directed test sequence
    initial begin
        int  cycles;
        logic seenValid;

        resetn = 1'b0;
        setReq(1'b0, 1'b0, 8'h00);
        setReq(1'b1, 1'b0, 8'h00);
        busA.rsp_ready = 1'b0;
        busB.rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset req_ready", 32'(busA.req_ready), 32'd0);
        checkOutput("reset rsp_valid", 32'(busA.rsp_valid), 32'd0);
        checkOutput("reset rsp_data", 32'(busA.rsp_data), 32'd0);
        checkOutput("reset busy", 32'(busyA), 32'd0);
        checkOutput("reset sck", 32'(sckA), 32'd0);
        checkOutput("reset ss", 32'(ssA), 32'd1);
        checkOutput("reset mosi", 32'(mosiA), 32'd1);
        resetn = 1'b1;
        checkOutput("release req_ready low", 32'(busA.req_ready), 32'd0);
        @(posedge clock); #1;
        checkOutput("release req_ready high", 32'(busA.req_ready), 32'd1);

        setReq(1'b0, 1'b1, 8'hA5);
        @(posedge clock); #1;
        setReq(1'b0, 1'b0, 8'h00);
        cycles = 0;
        while (slv[0].edgeCnt < 6 && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput("midreset reach bit 5", 32'(slv[0].edgeCnt), 32'd6);
        checkOutput("midreset busy before", 32'(busyA), 32'd1);
        resetn = 1'b0;
        @(posedge clock); #1;
        checkOutput("midreset ss", 32'(ssA), 32'd1);
        checkOutput("midreset sck", 32'(sckA), 32'd0);
        checkOutput("midreset mosi", 32'(mosiA), 32'd1);
        checkOutput("midreset busy", 32'(busyA), 32'd0);
        checkOutput("midreset rsp_valid", 32'(busA.rsp_valid), 32'd0);
        resetn = 1'b1;
        @(posedge clock); #1;
        checkOutput("midreset req_ready", 32'(busA.req_ready), 32'd1);
        seenValid = 1'b0;
        repeat (80) begin
            @(posedge clock); #1;
            seenValid |= busA.rsp_valid;
        end
        checkOutput("midreset no response", 32'(seenValid), 32'd0);

        applyStimulus(1'b0, 8'h01, 8'h80, 71, 0, 1'b0, "req01");
        applyStimulus(1'b0, 8'hA5, 8'hA5, 71, 0, 1'b0, "reqA5");
        checkOutput("b2b ss gap", 32'(lastGap >= 2), 32'd1);
        applyStimulus(1'b0, 8'h3C, 8'h3C, 71, 0, 1'b0, "req3C");
        applyStimulus(1'b0, 8'hF0, 8'h0F, 71, 0, 1'b0, "reqF0");
        applyStimulus(1'b0, 8'h55, 8'hAA, 71, 20, 1'b0, "stall55");
        applyStimulus(1'b0, 8'h12, 8'h48, 71, 0, 1'b0, "b2b12");
        checkOutput("b2b ss gap after stall", 32'(lastGap >= 2), 32'd1);

`ifdef SPI_BITREV_CHECK_EN
        forceZero = 1'b1;
        applyStimulus(1'b0, 8'h01, 8'h00, 71, 0, 1'b1, "forced");
        forceZero = 1'b0;
        checkOutput("chk sticky", 32'(chkStickyA), 32'd1);
        applyStimulus(1'b0, 8'h3C, 8'h3C, 71, 0, 1'b0, "after forced");
        checkOutput("chk sticky holds", 32'(chkStickyA), 32'd1);
`endif

        applyStimulus(1'b1, 8'h01, 8'h80, 36, 0, 1'b0, "fast01");
        applyStimulus(1'b1, 8'h12, 8'h48, 36, 0, 1'b0, "fast12");

        checkOutput("stray sck A", 32'(slv[0].strayEdges), 32'd0);
        checkOutput("stray sck B", 32'(slv[1].strayEdges), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
